// File: rtl/and_buf_inv_bank_pkg.sv
// Shared defaults for the and/buf/inv gate bank.
package and_buf_inv_bank_pkg;

    localparam int DEFAULT_WIDTH       = 1;
    localparam bit DEFAULT_REG_RST_VAL = 1'b0;

endpackage

// File: rtl/and_gate.sv
// Single-bit two-input AND cell.
module and_gate (
    input  logic a_in,
    input  logic b_in,
    output logic y_out
);

    assign y_out = a_in & b_in;

endmodule

// File: rtl/buffer.sv
// Single-bit buffer cell.
module buffer (
    input  logic a_in,
    output logic y_out
);

    assign y_out = a_in;

endmodule

// File: rtl/gate_bank_reg.sv
// WIDTH-wide load-enable register with synchronous reset to a fixed vector.
module gate_bank_reg #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Next state: take new data when enabled, otherwise hold.
    always_comb begin
        data_d = data_q;
        if (en_i) begin
            data_d = d_i;
        end
    end

    // State register; reset wins over the enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= RST_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/inverter.sv
// Single-bit inverter cell.
module inverter (
    input  logic a_in,
    output logic y_out
);

    assign y_out = ~a_in;

endmodule

// File: rtl/and_buf_inv_bank.sv
// Bank of per-bit AND / buffer / inverter gates with combinational and
// registered copies of each result plus a one-cycle load-valid flag.
module and_buf_inv_bank
    import and_buf_inv_bank_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter bit REG_RST_VAL = DEFAULT_REG_RST_VAL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] y_and_out,
    output logic [WIDTH-1:0] y_buf_out,
    output logic [WIDTH-1:0] y_inv_out,
    output logic [WIDTH-1:0] q_and_out,
    output logic [WIDTH-1:0] q_buf_out,
    output logic [WIDTH-1:0] q_inv_out,
    output logic             q_vld_out
);

    // Every registered bit resets to the same value, so the inverter
    // register does not hold ~buffer in the reset state.
    localparam logic [WIDTH-1:0] RST_VEC = {WIDTH{REG_RST_VAL}};

    logic vld_q;
    logic vld_d;

    // One lane per bit; lanes never share logic.
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        and_gate u_and (
            .a_in  (a_in[i]),
            .b_in  (b_in[i]),
            .y_out (y_and_out[i])
        );
        buffer u_buf (
            .a_in  (a_in[i]),
            .y_out (y_buf_out[i])
        );
        inverter u_inv (
            .a_in  (a_in[i]),
            .y_out (y_inv_out[i])
        );
    end

    gate_bank_reg #(.WIDTH(WIDTH), .RST_VAL(RST_VEC)) u_reg_and (
        .clk  (clk),
        .rst  (rst),
        .en_i (en_in),
        .d_i  (y_and_out),
        .q_o  (q_and_out)
    );

    gate_bank_reg #(.WIDTH(WIDTH), .RST_VAL(RST_VEC)) u_reg_buf (
        .clk  (clk),
        .rst  (rst),
        .en_i (en_in),
        .d_i  (y_buf_out),
        .q_o  (q_buf_out)
    );

    gate_bank_reg #(.WIDTH(WIDTH), .RST_VAL(RST_VEC)) u_reg_inv (
        .clk  (clk),
        .rst  (rst),
        .en_i (en_in),
        .d_i  (y_inv_out),
        .q_o  (q_inv_out)
    );

    // Valid pulses for exactly the cycle after a load.
    always_comb begin
        vld_d = en_in;
    end

    // Valid flag register; cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= 1'b0;
        end else begin
            vld_q <= vld_d;
        end
    end

    assign q_vld_out = vld_q;

endmodule

// File: tb/tb_and_buf_inv_bank.sv
// Directed self-checking bench for and_buf_inv_bank: a 1-bit instance for
// the exhaustive truth table and two 8-bit instances differing only in
// reset value.
module tb_and_buf_inv_bank;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       a1, b1;
    logic [7:0] a8, b8;

    logic       y1And, y1Buf, y1Inv, q1And, q1Buf, q1Inv, q1Vld;
    logic [7:0] y8And, y8Buf, y8Inv, q8And, q8Buf, q8Inv;
    logic       q8Vld;
    logic [7:0] y8rAnd, y8rBuf, y8rInv, q8rAnd, q8rBuf, q8rInv;
    logic       q8rVld;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    and_buf_inv_bank #(.WIDTH(1), .REG_RST_VAL(1'b0)) u1 (
        .clk(clk), .rst(rst), .en_in(en), .a_in(a1), .b_in(b1),
        .y_and_out(y1And), .y_buf_out(y1Buf), .y_inv_out(y1Inv),
        .q_and_out(q1And), .q_buf_out(q1Buf), .q_inv_out(q1Inv),
        .q_vld_out(q1Vld)
    );

    and_buf_inv_bank #(.WIDTH(8), .REG_RST_VAL(1'b0)) u8 (
        .clk(clk), .rst(rst), .en_in(en), .a_in(a8), .b_in(b8),
        .y_and_out(y8And), .y_buf_out(y8Buf), .y_inv_out(y8Inv),
        .q_and_out(q8And), .q_buf_out(q8Buf), .q_inv_out(q8Inv),
        .q_vld_out(q8Vld)
    );

    and_buf_inv_bank #(.WIDTH(8), .REG_RST_VAL(1'b1)) u8r (
        .clk(clk), .rst(rst), .en_in(en), .a_in(a8), .b_in(b8),
        .y_and_out(y8rAnd), .y_buf_out(y8rBuf), .y_inv_out(y8rInv),
        .q_and_out(q8rAnd), .q_buf_out(q8rBuf), .q_inv_out(q8rInv),
        .q_vld_out(q8rVld)
    );

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [7:0] obs,
                               input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] sweep [4];
        logic       expAnd [4];
        logic       expBuf [4];
        logic       expInv [4];

        sweep  = '{2'b00, 2'b01, 2'b10, 2'b11};
        expAnd = '{1'b0, 1'b0, 1'b0, 1'b1};
        expBuf = '{1'b0, 1'b0, 1'b1, 1'b1};
        expInv = '{1'b1, 1'b1, 1'b0, 1'b0};

        // Reset for two edges with all inputs high and enable asserted.
        rst = 1'b1; en = 1'b1;
        a1 = 1'b1; b1 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
        stepClock();
        checkOutput("rst1_y_and8", y8And, 8'hFF);
        checkOutput("rst1_y_and1", {7'd0, y1And}, 8'h01);
        stepClock();
        checkOutput("rst2_y_and8", y8And, 8'hFF);
        checkOutput("rst_q_and8", q8And, 8'h00);
        checkOutput("rst_q_buf8", q8Buf, 8'h00);
        checkOutput("rst_q_inv8", q8Inv, 8'h00);
        checkOutput("rst_q_vld8", {7'd0, q8Vld}, 8'h00);
        checkOutput("rst_q_and1", {7'd0, q1And}, 8'h00);
        checkOutput("rst_q_inv1", {7'd0, q1Inv}, 8'h00);
        checkOutput("rst_q_buf8r", q8rBuf, 8'hFF);
        checkOutput("rst_q_inv8r", q8rInv, 8'hFF);
        checkOutput("rst_q_vld8r", {7'd0, q8rVld}, 8'h00);

        // Exhaustive single-lane truth table, combinational only.
        rst = 1'b0; en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            {a1, b1} = sweep[i];
            #1;
            checkOutput($sformatf("tt%0d_and", i), {7'd0, y1And}, {7'd0, expAnd[i]});
            checkOutput($sformatf("tt%0d_buf", i), {7'd0, y1Buf}, {7'd0, expBuf[i]});
            checkOutput($sformatf("tt%0d_inv", i), {7'd0, y1Inv}, {7'd0, expInv[i]});
            #9;
        end

        // Single-cycle load, one-cycle latency.
        stepClock();
        a8 = 8'hF0; b8 = 8'h3C; en = 1'b1;
        stepClock();
        checkOutput("load_q_and", q8And, 8'h30);
        checkOutput("load_q_buf", q8Buf, 8'hF0);
        checkOutput("load_q_inv", q8Inv, 8'h0F);
        checkOutput("load_q_vld", {7'd0, q8Vld}, 8'h01);
        checkOutput("load_q_and_r", q8rAnd, 8'h30);
        checkOutput("load_q_inv_r", q8rInv, 8'h0F);
        en = 1'b0;
        stepClock();
        checkOutput("post_q_vld", {7'd0, q8Vld}, 8'h00);
        checkOutput("post_q_buf", q8Buf, 8'hF0);

        // Hold with a changing input.
        a8 = 8'hAA;
        #1;
        checkOutput("hold_y_buf", y8Buf, 8'hAA);
        checkOutput("hold_q_buf_now", q8Buf, 8'hF0);
        stepClock();
        checkOutput("hold_q_buf", q8Buf, 8'hF0);
        checkOutput("hold_q_inv", q8Inv, 8'h0F);
        checkOutput("hold_q_and", q8And, 8'h30);
        checkOutput("hold_q_vld", {7'd0, q8Vld}, 8'h00);

        // Lane independence.
        a8 = 8'h01; b8 = 8'h80;
        #1;
        checkOutput("lane_y_and", y8And, 8'h00);
        checkOutput("lane_y_inv", y8Inv, 8'hFE);
        checkOutput("lane_y_buf", y8Buf, 8'h01);

        // Reset has priority over a simultaneous enable.
        rst = 1'b1; en = 1'b1;
        stepClock();
        checkOutput("prio_q_and", q8And, 8'h00);
        checkOutput("prio_q_buf", q8Buf, 8'h00);
        checkOutput("prio_q_inv", q8Inv, 8'h00);
        checkOutput("prio_q_and_r", q8rAnd, 8'hFF);
        checkOutput("prio_q_buf_r", q8rBuf, 8'hFF);
        checkOutput("prio_q_inv_r", q8rInv, 8'hFF);
        checkOutput("prio_q_vld_r", {7'd0, q8rVld}, 8'h00);
        checkOutput("prio_y_and", y8And, 8'h00);

        // Load after reset release; inverter register is ~buffer again.
        rst = 1'b0;
        stepClock();
        checkOutput("reload_q_and_r", q8rAnd, 8'h00);
        checkOutput("reload_q_buf_r", q8rBuf, 8'h01);
        checkOutput("reload_q_inv_r", q8rInv, 8'hFE);
        checkOutput("reload_q_vld_r", {7'd0, q8rVld}, 8'h01);
        checkOutput("reload_q_inv", q8Inv, 8'hFE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/and_buf_inv_bank.md
Name: and_buf_inv_bank

Overview:
- Parameterized bank of bitwise primitive gates on two input vectors.
- Per bit:
  - AND of a_in and b_in.
  - Buffer of a_in.
  - Inverter of a_in.
- Each function has a combinational output and a registered output, so the bank can sit directly in a datapath or at a pipeline boundary.
- Built from per-bit instances of the codebase's existing and_gate, buffer and inverter cells.

Parameters:
- WIDTH, 1, number of bit lanes (>=1).
- REG_RST_VAL, 0, value loaded into every registered output on reset. Applied to all WIDTH bits: all-zero when 0, all-one when 1.

Ports:
- clk  input  1  single system clock; all registers update on its rising edge.
- rst  input  1  synchronous, active-high reset, sampled on rising clk.
- en_in  input  1  register load enable for the q_* outputs.
- a_in  input  WIDTH  operand A.
- b_in  input  WIDTH  operand B; used only by the AND function.
- y_and_out  output  WIDTH  combinational a_in & b_in.
- y_buf_out  output  WIDTH  combinational a_in.
- y_inv_out  output  WIDTH  combinational ~a_in.
- q_and_out  output  WIDTH  registered AND.
- q_buf_out  output  WIDTH  registered buffer.
- q_inv_out  output  WIDTH  registered inverter.
- q_vld_out  output  1  high for one cycle after a cycle in which en_in=1 loaded the q_* outputs.

Behaviour:
- Combinational paths (y_*):
  - Zero latency, no clock dependence.
  - Valid during reset.
  - Bit i depends only on a_in[i] and b_in[i]; no cross-lane logic.
- Per-bit truth table for (a,b) = 00, 01, 10, 11:
  - and = 0, 0, 0, 1.
  - buf = 0, 0, 1, 1.
  - inv = 1, 1, 0, 0.
- X/Z on an input propagates per standard gate semantics; the block adds no masking.
- Registered paths (q_*):
  - Rising clk with rst=1: q_and_out, q_buf_out and q_inv_out load REG_RST_VAL replicated across all bits; q_vld_out loads 0. Reset has priority over en_in.
  - Rising clk with rst=0 and en_in=1: q_and_out, q_buf_out and q_inv_out load the current y_and_out, y_buf_out and y_inv_out (one-cycle latency); q_vld_out loads 1.
  - Rising clk with rst=0 and en_in=0: q_and_out, q_buf_out and q_inv_out hold their values; q_vld_out loads 0.
- Reset asserted mid-stream: takes effect at the next rising edge. Registered values are discarded, not completed.
- No handshake or backpressure; en_in is sampled every cycle.
- Before the first reset, the q_* outputs are undefined; benches must apply rst for at least one clk edge.
- Invariant after any loading edge: q_inv_out == ~q_buf_out. This does not hold in the reset state, because reset loads the same value into both.

Decomposition:
- Shared package: WIDTH default constant and REG_RST_VAL default constant only. No typedefs required.
- Sub-modules: per-bit instances of the existing and_gate, buffer and inverter cells (ports a_in, b_in, y_out). Instantiate them in a generate loop over WIDTH.
- One natural new sub-module: gate_bank_reg, a WIDTH-wide enable register with synchronous reset, instantiated three times plus a 1-bit valid flop.

Test Plan:
- Exhaustive single lane (WIDTH=1): sweep {a_in,b_in} = 00, 01, 10, 11 at 10-time-unit steps.
  - y_and_out: 0, 0, 0, 1.
  - y_inv_out: 1, 1, 0, 0.
  - y_buf_out: 0, 0, 1, 1.
  - All updates are immediate.
- Reset: hold rst=1 for 2 cycles with a_in=1, b_in=1, en_in=1.
  - q_and_out, q_buf_out and q_inv_out = 0 (REG_RST_VAL=0); q_vld_out = 0.
  - y_and_out = 1 throughout.
- Register latency (WIDTH=8):
  - Set a_in=8'hF0, b_in=8'h3C, en_in=1 for one cycle.
  - Next cycle: q_and_out=8'h30, q_buf_out=8'hF0, q_inv_out=8'h0F, q_vld_out=1.
  - Following cycle, with en_in=0: q_vld_out=0.
- Hold: with en_in=0, change a_in to 8'hAA.
  - q_buf_out stays 8'hF0; y_buf_out=8'hAA immediately.
- Reset priority: rst=1 and en_in=1 in the same cycle.
  - Next cycle: q_* outputs = REG_RST_VAL replicated; with REG_RST_VAL=1 and WIDTH=8, each is 8'hFF.
- Lane independence (WIDTH=8): a_in=8'h01, b_in=8'h80.
  - y_and_out=8'h00, y_inv_out=8'hFE.
